dbram_inst: RTL and testbench

- Data-array SRAM of the L1 data cache: 2048 x 32-bit words with per-byte write enables, one synchronous read port and one write port.
- The cache controller drives the write port for line fills (all bytes) and store hits (byte-masked).
- The load pipeline reads through the read port with 1-cycle latency.
- Maps to a single simple-dual-port block RAM.

---
 rtl/dbram_inst.sv | 53 +++++
 tb/tb_dbram_inst.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dbram_inst.sv
// L1 data-cache data array: 2**ADDR_W x DATA_W words, byte-masked write port, 1-cycle read port.
// Optional DBRAM_WR_FWD_EN: same-address write-first forwarding onto the read data.
module dbram_inst #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32,
   localparam int unsigned BE_W  = DATA_W / 8
) (
   input  logic              cpu_clock_i,
   input  logic              cpu_reset_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic [BE_W-1:0]   wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   // Power-up contents are zero; reset never touches the array.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] rd_word;

   always_ff @(posedge cpu_clock_i) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
         if (wr_en_i[i]) begin
            mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem[rd_addr_i];
`ifdef DBRAM_WR_FWD_EN
      if (rd_addr_i == wr_addr_i) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (wr_en_i[i]) begin
               rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
            end
         end
      end
`endif
   end

   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         rd_data_o <= '0;
      end else if (rd_en_i) begin
         rd_data_o <= rd_word;
      end
   end

endmodule

// File: tb/tb_dbram_inst.sv
// Self-checking bench for dbram_inst: directed plan steps followed by random traffic vs. an array model.
module tb_dbram_inst;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_en = 1'b0;
   logic [10:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic [3:0]  wr_en = '0;
   logic [10:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   logic [31:0] mdl [2048];
   logic [31:0] exp_rd = 'x;

   always #5 clk = ~clk;

   dbram_inst #(.ADDR_W(11), .DATA_W(32)) dut (
      .cpu_clock_i(clk),
      .cpu_reset_i(rst),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // One clock: drive, update the model at the edge, check 1 time unit later.
   task automatic cyc(input logic re, input logic [10:0] ra, input logic [3:0] we,
                      input logic [10:0] wa, input logic [31:0] wd, input logic rs,
                      input string tag);
      logic [31:0] old;
      rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; rst = rs;
      @(posedge clk);
      if (rs) exp_rd = '0;
      else if (re) begin
         old = mdl[ra];
`ifdef DBRAM_WR_FWD_EN
         if (ra == wa) old = merge(old, wd, we);
`endif
         exp_rd = old;
      end
      mdl[wa] = merge(mdl[wa], wd, we);
      #1;
      nvec++;
      assert (rd_data === exp_rd) else begin
         nerr++;
         $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, exp_rd);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] want);
      nvec++;
      assert (rd_data === want) else begin
         nerr++;
         $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, want);
      end
   endtask

   initial begin
      for (int a = 0; a < 2048; a++) mdl[a] = '0;
      @(negedge clk);

      // Reset with a pending read: output forced to zero.
      cyc(1'b1, 11'h000, 4'h0, 11'h000, 32'h0, 1'b1, "reset0"); chk("reset0_c", 32'h0);
      cyc(1'b1, 11'h000, 4'h0, 11'h000, 32'h0, 1'b1, "reset1"); chk("reset1_c", 32'h0);
      cyc(1'b0, 11'h000, 4'h0, 11'h000, 32'h0, 1'b0, "post_reset"); chk("post_reset_c", 32'h0);

      // Full word write at the top address, then read back.
      cyc(1'b0, 11'h000, 4'hF, 11'h7FF, 32'hDEADBEEF, 1'b0, "wr_7ff");
      cyc(1'b1, 11'h7FF, 4'h0, 11'h000, 32'h0, 1'b0, "rd_7ff"); chk("rd_7ff_c", 32'hDEADBEEF);

      // Byte masking, then an all-zero-enable write.
      cyc(1'b0, 11'h000, 4'b0101, 11'h7FF, 32'h11223344, 1'b0, "wr_mask");
      cyc(1'b1, 11'h7FF, 4'h0, 11'h000, 32'h0, 1'b0, "rd_mask"); chk("rd_mask_c", 32'hDE22BE44);
      cyc(1'b0, 11'h000, 4'h0, 11'h7FF, 32'hFFFFFFFF, 1'b0, "wr_none");
      cyc(1'b1, 11'h7FF, 4'h0, 11'h000, 32'h0, 1'b0, "rd_none"); chk("rd_none_c", 32'hDE22BE44);

      // Hold while disabled, even as the location is overwritten.
      cyc(1'b0, 11'h000, 4'hF, 11'h005, 32'hA5A5A5A5, 1'b0, "wr_5");
      cyc(1'b1, 11'h005, 4'h0, 11'h000, 32'h0, 1'b0, "rd_5"); chk("rd_5_c", 32'hA5A5A5A5);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 11'h005, 4'hF, 11'h005, 32'h0, 1'b0, "hold");
         chk("hold_c", 32'hA5A5A5A5);
      end
      cyc(1'b1, 11'h005, 4'h0, 11'h000, 32'h0, 1'b0, "rd_5_new"); chk("rd_5_new_c", 32'h0);

      // Same-address collision.
      cyc(1'b1, 11'h010, 4'b1100, 11'h010, 32'hCAFEF00D, 1'b0, "collide");
`ifdef DBRAM_WR_FWD_EN
      chk("collide_c", 32'hCAFE0000);
`else
      chk("collide_c", 32'h00000000);
`endif
      cyc(1'b1, 11'h010, 4'h0, 11'h000, 32'h0, 1'b0, "after_collide");
      chk("after_collide_c", 32'hCAFE0000);

      // Fill sweep with a trailing read and a reset pulse mid-way.
      for (int k = 0; k < 32; k++) begin
         logic [10:0] ka, pa;
         ka = 11'(k);
         pa = 11'(k - 1);
         cyc(k > 0, pa, 4'hF, ka, 32'(k) * 32'h01010101, k == 16, "sweep");
         if (k == 16) chk("sweep_rst_c", 32'h0);
         else if (k > 0) chk("sweep_c", 32'(k - 1) * 32'h01010101);
      end
      for (int k = 0; k < 32; k++) begin
         cyc(1'b1, 11'(k), 4'h0, 11'h400, 32'h0, 1'b0, "sweep_rb");
         chk("sweep_rb_c", 32'(k) * 32'h01010101);
      end

      // Random traffic over a narrow address window to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)), 4'($urandom),
             11'($urandom_range(0, 15)), $urandom, $urandom_range(0, 19) == 0, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
